// File: rtl/fetch_stage.sv
// Instruction fetch stage: presents a PC to a one-cycle-latency instruction
// memory and hands the returned word, its address and a valid flag to decode.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic [15:0] mem_raddr,
    output logic        mem_stall,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr_out,
    output logic [15:0] pc_out,
    output logic        valid_out,
    output logic [15:0] fetch_count
);

    logic [15:0] pc_f;
    logic [15:0] pc_d;
    logic        v_d;
    logic        halted;
    logic        halt_pend;
    logic        halt_req;
    logic        deliver;

    // A halt seen while stalled or redirecting is remembered in halt_pend
    // and takes effect on the first free-running cycle.
    assign halt_req  = halt | halt_pend;
    assign deliver   = valid_out & ~stall;

    assign mem_raddr = pc_f;
    assign mem_stall = stall & ~redirect;
    assign instr_out = mem_rdata;
    assign pc_out    = pc_d;
    assign valid_out = v_d & ~redirect;

    // NOTE: non-blocking assignments so every branch below sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f        <= RESET_PC;
            pc_d        <= RESET_PC;
            v_d         <= 1'b0;
            halted      <= 1'b0;
            halt_pend   <= 1'b0;
            fetch_count <= 16'h0000;
        end else begin
            if (deliver) begin
                fetch_count <= fetch_count + 16'h0001;
            end
            if (!halted) begin
                if (redirect) begin
                    pc_f      <= redirect_pc;
                    v_d       <= 1'b0;
                    halt_pend <= halt_req;
                end else if (stall) begin
                    halt_pend <= halt_req;
                end else if (halt_req) begin
                    // The word currently on valid_out is delivered this edge.
                    halted    <= 1'b1;
                    halt_pend <= 1'b0;
                    v_d       <= 1'b0;
                end else begin
                    pc_f <= pc_f + 16'h0001;
                    pc_d <= pc_f;
                    v_d  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall, redirect, halt and
// PC wrap-around, against a registered memory holding (address ^ TAG).
module tb_fetch_stage;

    localparam logic [15:0] TAG = 16'h5A00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] mem_raddr, mem_rdata, instr_out, pc_out, fetch_count;
    logic        mem_stall, valid_out;

    logic [15:0] w_raddr, w_rdata, w_instr, w_pc, w_count;
    logic        w_mstall, w_valid;

    int total = 0;
    int bad = 0;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .mem_raddr(mem_raddr),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata), .instr_out(instr_out),
        .pc_out(pc_out), .valid_out(valid_out), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(16'h0000), .halt(1'b0), .mem_raddr(w_raddr),
        .mem_stall(w_mstall), .mem_rdata(w_rdata), .instr_out(w_instr),
        .pc_out(w_pc), .valid_out(w_valid), .fetch_count(w_count)
    );

    always #5 clk = ~clk;

    // Instruction memories with one-cycle registered read and output hold.
    always @(posedge clk) if (!mem_stall) mem_rdata <= mem_raddr ^ TAG;
    always @(posedge clk) if (!w_mstall) w_rdata <= w_raddr ^ TAG;

    // Leaves the bench in cycle 0 after release (rst_n just risen, stall low).
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b1; redirect = 1'b0; halt = 1'b0; redirect_pc = 16'h0000;
        #1;
        if ({valid_out, pc_out, mem_raddr, fetch_count, mem_stall} !== {1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got v=%b pc=%h raddr=%h cnt=%h mstall=%b, want v=0 pc=0000 raddr=0000 cnt=0000 mstall=1",
                     valid_out, pc_out, mem_raddr, fetch_count, mem_stall);
        end
        total++;
        if ({w_valid, w_pc, w_raddr, w_count} !== {1'b0, 16'hFFFE, 16'hFFFE, 16'h0000}) begin
            bad++;
            $display("FAIL reset_state_wrap: got v=%b pc=%h raddr=%h cnt=%h, want v=0 pc=fffe raddr=fffe cnt=0000",
                     w_valid, w_pc, w_raddr, w_count);
        end
        total++;
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        #1;
        if ({valid_out, mem_raddr, mem_stall, fetch_count} !== {1'b0, 16'h0000, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL reset_release: got v=%b raddr=%h mstall=%b cnt=%h, want v=0 raddr=0000 mstall=0 cnt=0000",
                     valid_out, mem_raddr, mem_stall, fetch_count);
        end
        total++;
    endtask

    task automatic test_sequence();
        for (int i = 0; i < 4; i++) begin
            logic [15:0] e_pc;
            e_pc = 16'(i);
            @(negedge clk); #1;
            if ({valid_out, pc_out, instr_out, fetch_count, mem_raddr} !==
                {1'b1, e_pc, e_pc ^ TAG, e_pc, e_pc + 16'h0001}) begin
                bad++;
                $display("FAIL seq[%0d]: got v=%b pc=%h ins=%h cnt=%h raddr=%h, want v=1 pc=%h ins=%h cnt=%h raddr=%h",
                         i, valid_out, pc_out, instr_out, fetch_count, mem_raddr,
                         e_pc, e_pc ^ TAG, e_pc, e_pc + 16'h0001);
            end
            total++;
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); stall = 1'b1; #1;
            if ({valid_out, pc_out, instr_out, fetch_count, mem_stall, mem_raddr} !==
                {1'b1, 16'h0004, 16'h0004 ^ TAG, 16'h0004, 1'b1, 16'h0005}) begin
                bad++;
                $display("FAIL stall[%0d]: got v=%b pc=%h ins=%h cnt=%h mstall=%b raddr=%h, want v=1 pc=0004 ins=%h cnt=0004 mstall=1 raddr=0005",
                         k, valid_out, pc_out, instr_out, fetch_count, mem_stall, mem_raddr, 16'h0004 ^ TAG);
            end
            total++;
        end
        @(negedge clk); stall = 1'b0; #1;
        if ({valid_out, pc_out, fetch_count, mem_stall} !== {1'b1, 16'h0004, 16'h0004, 1'b0}) begin
            bad++;
            $display("FAIL stall_release: got v=%b pc=%h cnt=%h mstall=%b, want v=1 pc=0004 cnt=0004 mstall=0",
                     valid_out, pc_out, fetch_count, mem_stall);
        end
        total++;
        @(negedge clk); #1;
        if ({valid_out, pc_out, instr_out, fetch_count} !== {1'b1, 16'h0005, 16'h0005 ^ TAG, 16'h0005}) begin
            bad++;
            $display("FAIL stall_resume: got v=%b pc=%h ins=%h cnt=%h, want v=1 pc=0005 ins=%h cnt=0005",
                     valid_out, pc_out, instr_out, fetch_count, 16'h0005 ^ TAG);
        end
        total++;
    endtask

    task automatic test_redirect();
        @(negedge clk); #1;
        @(negedge clk); redirect = 1'b1; redirect_pc = 16'h0100; #1;
        if ({valid_out, pc_out, fetch_count, mem_stall} !== {1'b0, 16'h0007, 16'h0007, 1'b0}) begin
            bad++;
            $display("FAIL redirect_squash: got v=%b pc=%h cnt=%h mstall=%b, want v=0 pc=0007 cnt=0007 mstall=0",
                     valid_out, pc_out, fetch_count, mem_stall);
        end
        total++;
        @(negedge clk); redirect = 1'b0; #1;
        if ({valid_out, mem_raddr, fetch_count} !== {1'b0, 16'h0100, 16'h0007}) begin
            bad++;
            $display("FAIL redirect_bubble: got v=%b raddr=%h cnt=%h, want v=0 raddr=0100 cnt=0007",
                     valid_out, mem_raddr, fetch_count);
        end
        total++;
        for (int i = 0; i < 2; i++) begin
            logic [15:0] e_pc;
            e_pc = 16'h0100 + 16'(i);
            @(negedge clk); #1;
            if ({valid_out, pc_out, instr_out, fetch_count} !== {1'b1, e_pc, e_pc ^ TAG, 16'h0007 + 16'(i)}) begin
                bad++;
                $display("FAIL redirect_target[%0d]: got v=%b pc=%h ins=%h cnt=%h, want v=1 pc=%h ins=%h cnt=%h",
                         i, valid_out, pc_out, instr_out, fetch_count, e_pc, e_pc ^ TAG, 16'h0007 + 16'(i));
            end
            total++;
        end
    endtask

    task automatic test_redirect_stall();
        @(negedge clk); stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200; #1;
        if ({mem_stall, valid_out, pc_out, fetch_count} !== {1'b0, 1'b0, 16'h0102, 16'h0009}) begin
            bad++;
            $display("FAIL redir_stall_cycle: got mstall=%b v=%b pc=%h cnt=%h, want mstall=0 v=0 pc=0102 cnt=0009",
                     mem_stall, valid_out, pc_out, fetch_count);
        end
        total++;
        @(negedge clk); stall = 1'b0; redirect = 1'b0; #1;
        if ({valid_out, mem_raddr, fetch_count} !== {1'b0, 16'h0200, 16'h0009}) begin
            bad++;
            $display("FAIL redir_stall_bubble: got v=%b raddr=%h cnt=%h, want v=0 raddr=0200 cnt=0009",
                     valid_out, mem_raddr, fetch_count);
        end
        total++;
        @(negedge clk); #1;
        if ({valid_out, pc_out, instr_out, fetch_count} !== {1'b1, 16'h0200, 16'h0200 ^ TAG, 16'h0009}) begin
            bad++;
            $display("FAIL redir_stall_target: got v=%b pc=%h ins=%h cnt=%h, want v=1 pc=0200 ins=%h cnt=0009",
                     valid_out, pc_out, instr_out, fetch_count, 16'h0200 ^ TAG);
        end
        total++;
    endtask

    task automatic test_halt();
        test_reset();
        repeat (3) @(negedge clk);
        @(negedge clk); halt = 1'b1; #1;
        if ({valid_out, pc_out, fetch_count} !== {1'b1, 16'h0003, 16'h0003}) begin
            bad++;
            $display("FAIL halt_cycle: got v=%b pc=%h cnt=%h, want v=1 pc=0003 cnt=0003",
                     valid_out, pc_out, fetch_count);
        end
        total++;
        @(negedge clk); halt = 1'b0; #1;
        if ({valid_out, mem_raddr, fetch_count} !== {1'b0, 16'h0004, 16'h0004}) begin
            bad++;
            $display("FAIL halt_after: got v=%b raddr=%h cnt=%h, want v=0 raddr=0004 cnt=0004",
                     valid_out, mem_raddr, fetch_count);
        end
        total++;
        @(negedge clk); redirect = 1'b1; redirect_pc = 16'h0300;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); redirect = 1'b0; #1;
            if ({valid_out, mem_raddr, fetch_count} !== {1'b0, 16'h0004, 16'h0004}) begin
                bad++;
                $display("FAIL halt_ignores_redirect[%0d]: got v=%b raddr=%h cnt=%h, want v=0 raddr=0004 cnt=0004",
                         k, valid_out, mem_raddr, fetch_count);
            end
            total++;
        end
        @(negedge clk); rst_n = 1'b0; #1;
        if ({valid_out, pc_out, mem_raddr, fetch_count} !== {1'b0, 16'h0000, 16'h0000, 16'h0000}) begin
            bad++;
            $display("FAIL async_reset: got v=%b pc=%h raddr=%h cnt=%h, want v=0 pc=0000 raddr=0000 cnt=0000",
                     valid_out, pc_out, mem_raddr, fetch_count);
        end
        total++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        if ({valid_out, pc_out, instr_out, fetch_count} !== {1'b1, 16'h0000, 16'h0000 ^ TAG, 16'h0000}) begin
            bad++;
            $display("FAIL halt_restart: got v=%b pc=%h ins=%h cnt=%h, want v=1 pc=0000 ins=%h cnt=0000",
                     valid_out, pc_out, instr_out, fetch_count, 16'h0000 ^ TAG);
        end
        total++;
    endtask

    task automatic test_halt_stall();
        @(negedge clk); stall = 1'b1; halt = 1'b1; #1;
        if ({valid_out, pc_out, fetch_count, mem_stall} !== {1'b1, 16'h0001, 16'h0001, 1'b1}) begin
            bad++;
            $display("FAIL halt_stall_req: got v=%b pc=%h cnt=%h mstall=%b, want v=1 pc=0001 cnt=0001 mstall=1",
                     valid_out, pc_out, fetch_count, mem_stall);
        end
        total++;
        @(negedge clk); halt = 1'b0; #1;
        @(negedge clk); stall = 1'b0; #1;
        if ({valid_out, pc_out, fetch_count} !== {1'b1, 16'h0001, 16'h0001}) begin
            bad++;
            $display("FAIL halt_stall_held: got v=%b pc=%h cnt=%h, want v=1 pc=0001 cnt=0001",
                     valid_out, pc_out, fetch_count);
        end
        total++;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            if ({valid_out, mem_raddr, fetch_count} !== {1'b0, 16'h0002, 16'h0002}) begin
                bad++;
                $display("FAIL halt_stall_halted[%0d]: got v=%b raddr=%h cnt=%h, want v=0 raddr=0002 cnt=0002",
                         k, valid_out, mem_raddr, fetch_count);
            end
            total++;
        end
    endtask

    task automatic test_wrap();
        test_reset();
        if ({w_valid, w_raddr} !== {1'b0, 16'hFFFE}) begin
            bad++;
            $display("FAIL wrap_cycle0: got v=%b raddr=%h, want v=0 raddr=fffe", w_valid, w_raddr);
        end
        total++;
        for (int i = 0; i < 3; i++) begin
            logic [15:0] e_pc;
            e_pc = 16'hFFFE + 16'(i);
            @(negedge clk); #1;
            if ({w_valid, w_pc, w_instr, w_count} !== {1'b1, e_pc, e_pc ^ TAG, 16'(i)}) begin
                bad++;
                $display("FAIL wrap[%0d]: got v=%b pc=%h ins=%h cnt=%h, want v=1 pc=%h ins=%h cnt=%h",
                         i, w_valid, w_pc, w_instr, w_count, e_pc, e_pc ^ TAG, 16'(i));
            end
            total++;
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_halt();
        test_halt_stall();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: first instruction address fetched after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  downstream hold; keep current instruction and PC.
REQ-005 redirect  input  1  branch/jump taken; discard in-flight fetch.
REQ-006 redirect_pc  input  16  new fetch address, sampled when redirect=1.
REQ-007 halt  input  1  stop issuing new fetches; sticky until reset.
REQ-008 mem_raddr  output  16  word address to instruction read port; combinational from fetch PC.
REQ-009 mem_stall  output  1  hold for instruction memory output register.
REQ-010 mem_rdata  input  16  instruction word; valid one cycle after mem_raddr when mem_stall=0.
REQ-011 instr_out  output  16  instruction to decode; equals mem_rdata.
REQ-012 pc_out  output  16  address of instr_out.
REQ-013 valid_out  output  1  instr_out/pc_out carry a real instruction.
REQ-014 fetch_count  output  16  instructions delivered (valid_out=1 and stall=0 cycles).

Function
REQ-015 Internal regs: pc_f (address being presented), pc_d (address whose word is on mem_rdata), v_d (in-flight valid), halted (sticky).
REQ-016 mem_raddr SHALL equal pc_f every cycle.
REQ-017 mem_stall SHALL equal stall & ~redirect.
REQ-018 Read latency is one cycle: word for pc_f issued in cycle N appears on mem_rdata in N+1 with pc_out=pc_f(N).
REQ-019 Advance (stall=0, redirect=0, halted=0): pc_f <= pc_f+1 mod 2^16; pc_d <= pc_f; v_d <= 1.
REQ-020 Stall (stall=1, redirect=0): pc_f, pc_d, v_d, fetch_count unchanged; memory output held via mem_stall.
REQ-021 Redirect (redirect=1) overrides stall and halt-in-progress of current cycle: pc_f <= redirect_pc; v_d <= 0; following cycle presents redirect_pc, next cycle delivers it (one bubble).
REQ-022 Redirect asserted while halted SHALL be ignored; halted persists until reset.
REQ-023 halt=1 with stall=0, redirect=0: halted <= 1; current valid_out instruction still delivered; v_d <= 0 thereafter; pc_f frozen.
REQ-024 halt=1 with stall=1: halted set only when stall drops (held request not lost; latched internally).
REQ-025 valid_out SHALL equal v_d & ~redirect (in-flight word squashed combinationally in the redirect cycle).
REQ-026 fetch_count increments by 1 (wrap at 16'hFFFF->0) each cycle valid_out=1 and stall=0.
REQ-027 pc_f wrap-around: 16'hFFFF advances to 16'h0000 without error or bubble.
REQ-028 Simultaneous redirect and halt: redirect applied, halt latched, halted set next cycle.

Reset
REQ-029 On rst_n=0 asynchronously: pc_f=RESET_PC, pc_d=RESET_PC, v_d=0, halted=0, fetch_count=0; therefore valid_out=0, pc_out=RESET_PC, mem_raddr=RESET_PC, mem_stall=stall.
REQ-030 Reset mid-stall or mid-redirect discards all in-flight state; first valid_out=1 is exactly one cycle after rst_n rises, pc_out=RESET_PC.
REQ-031 No output SHALL depend on the pre-reset value of any register.

Verification
REQ-032 Release reset, no stall, memory holds word i at address i -> valid_out=1 from cycle 1, pc_out/instr_out = 0,1,2,... one per cycle; fetch_count=5 after 5 delivering cycles.
REQ-033 stall=1 for 3 cycles at pc_out=4 -> pc_out=4, instr_out unchanged, fetch_count frozen, mem_stall=1; resumes with 5 after release.
REQ-034 redirect=1, redirect_pc=16'h0100 at pc_out=7 -> valid_out=0 that cycle, one bubble, then pc_out=16'h0100, 16'h0101.
REQ-035 redirect during stall=1 -> mem_stall=0 that cycle, target delivered after one bubble despite stall continuing to be low afterward.
REQ-036 RESET_PC=16'hFFFE -> pc_out sequence FFFE, FFFF, 0000 with no bubble.
REQ-037 halt=1 at pc_out=3 -> instruction 3 delivered, valid_out=0 forever after, redirect ignored, rst_n pulse restarts at RESET_PC.
